sram_packet_loader: RTL and testbench
=====================================

SRAM_PACKET_LOADER -- requirements
Module: sram_packet_loader

Interface
REQ-001 Parameter PACKET_W, default 55, SHALL set the packet width presented to the SRAM input controller.
REQ-002 Parameter DATA_W, default 32, SHALL set the read-back data width taken from the SRAM output mux.
REQ-003 Parameter READ_LAT, default 2, range 1..15, SHALL set the cycles from packet_valid to the read_data sample edge.
REQ-004 clk_in  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 scan_en  input  1  SHALL frame a serial packet; high while bits are presented.
REQ-007 scan_in  input  1  SHALL carry packet bits, MSB first, one per cycle while scan_en=1.
REQ-008 cs_in  input  1  SHALL give the SRAM select for the frame, sampled on the frame's first bit.
REQ-009 err_clr  input  1  SHALL clear frame_err when high.
REQ-010 read_data  input  DATA_W  SHALL be the selected SRAM read word.
REQ-011 packet  output  PACKET_W  SHALL be the assembled packet, held stable between issues.
REQ-012 chip_select  output  1  SHALL be the latched cs_in of the last issued packet.
REQ-013 packet_valid  output  1  SHALL pulse one cycle when a new packet is issued.
REQ-014 scan_out  output  1  SHALL carry read-back bits, MSB first.
REQ-015 busy  output  1  SHALL be high in every state except IDLE.
REQ-016 frame_err  output  1  SHALL be a sticky flag for malformed frames.

Function
REQ-017 FSM states SHALL be IDLE, SHIFT, ISSUE, WAIT, UNLOAD.
REQ-018 IDLE with scan_en=1: shift scan_in into the shift-register LSB, latch cs_in, bit count=1, go SHIFT.
REQ-019 SHIFT with scan_en=1: shift, count+1; on the PACKET_W-th bit go ISSUE.
REQ-020 SHIFT with scan_en=0 before PACKET_W bits: set frame_err, discard bits, go IDLE, no packet_valid, packet/chip_select unchanged.
REQ-021 ISSUE (one cycle): copy shift register to packet and latched cs to chip_select, both registered and visible this cycle; packet_valid=1; load the wait counter with READ_LAT; go WAIT.
REQ-022 WAIT: decrement each cycle; on the clock edge ending the READ_LAT-th WAIT cycle, capture read_data into the unload register and go UNLOAD.
REQ-023 UNLOAD: scan_out SHALL present captured bit DATA_W-1 in the first cycle, down to bit 0 in cycle DATA_W, then go IDLE.
REQ-024 scan_out SHALL be 0 outside UNLOAD.
REQ-025 scan_en=1 in ISSUE, WAIT or UNLOAD SHALL set frame_err, SHALL be otherwise ignored, and SHALL NOT start a frame.
REQ-026 scan_en=1 in the first cycle back in IDLE SHALL start a new frame (back-to-back allowed).
REQ-027 If err_clr and a new error occur in the same cycle, set SHALL win.
REQ-028 The bit counter SHALL be ceil(log2(PACKET_W+1)) bits wide, unsigned, and SHALL never wrap within a frame.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE and packet=0, chip_select=0, packet_valid=0, scan_out=0, busy=0, frame_err=0, and all counters and shift registers to 0.
REQ-030 Reset mid-frame or mid-unload SHALL abort with no packet_valid emitted after release.
REQ-031 The first post-release edge with scan_en=1 SHALL be treated as a first bit.

Structure
REQ-032 Package sram_packet_pkg SHALL hold the state enum, PACKET_W/DATA_W defaults and counter-width constants.
REQ-033 The unload path SHALL be the sub-module readback_serializer (load, shift, scan_out).

Verification
REQ-034 55-bit frame 0x55AA_55AA_55AA_55 (MSB first), cs_in=1 -> packet_valid in the cycle after bit 55, packet matches, chip_select=1, busy high.
REQ-035 read_data=0xDEADBEEF at the sample edge, READ_LAT=2 -> scan_out streams 1101_1110...1110_1111 over 32 cycles starting 3 cycles after packet_valid, then busy=0.
REQ-036 scan_en dropped after 20 bits -> frame_err=1, no packet_valid, packet holds its previous value; err_clr pulse -> frame_err=0.
REQ-037 scan_en=1 during UNLOAD -> frame_err=1, scan_out stream unchanged; err_clr and violation in the same cycle -> frame_err stays 1.
REQ-038 rst_n low at bit 30 -> all outputs 0 asynchronously; a full frame after release issues normally.
REQ-039 Two back-to-back frames, second starting on the first IDLE cycle -> two packet_valid pulses, both packets and both read-back streams correct.

Source files
------------

// File: rtl/sram_packet_pkg.sv
// Shared types and sizing helpers for the serial SRAM packet loader.
// Holds the FSM state encoding, default widths and counter-width constants.
package sram_packet_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_UNLOAD = 3'd4
    } state_t;

    localparam int PACKET_W_DEF = 55;
    localparam int DATA_W_DEF   = 32;
    localparam int READ_LAT_DEF = 2;

    // READ_LAT tops out at 15, so four bits always hold the wait count.
    localparam int WAIT_CNT_W   = 4;

    // Width of an unsigned counter that must reach n without wrapping.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sram_packet_loader_if.sv
// Serial scan / SRAM-side bundle of the packet loader.
// The master side drives the scan chain and the read word; the slave side is the loader.
interface sram_packet_loader_if
    import sram_packet_pkg::*;
#(
    parameter int PACKET_W = PACKET_W_DEF,
    parameter int DATA_W   = DATA_W_DEF
) ();

    logic                scan_en;
    logic                scan_in;
    logic                cs_in;
    logic                err_clr;
    logic [DATA_W-1:0]   read_data;
    logic [PACKET_W-1:0] packet;
    logic                chip_select;
    logic                packet_valid;
    logic                scan_out;
    logic                busy;
    logic                frame_err;

    modport master (
        output scan_en, scan_in, cs_in, err_clr, read_data,
        input  packet, chip_select, packet_valid, scan_out, busy, frame_err
    );

    modport slave (
        input  scan_en, scan_in, cs_in, err_clr, read_data,
        output packet, chip_select, packet_valid, scan_out, busy, frame_err
    );

endinterface

// File: rtl/readback_serializer.sv
// Parallel-in, serial-out read-back path: presents the captured word MSB first.
// Zeros are shifted in, so scan_out returns to 0 after the last data bit.
module readback_serializer
    import sram_packet_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] data,
    output logic              scan_out
);

    logic [DATA_W-1:0] shift_r;
    logic              scan_out_r;

    // Capture the read word with its MSB already on scan_out, then shift toward the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r    <= '0;
            scan_out_r <= 1'b0;
        end else if (load) begin
            shift_r    <= {data[DATA_W-2:0], 1'b0};
            scan_out_r <= data[DATA_W-1];
        end else if (shift) begin
            shift_r    <= {shift_r[DATA_W-2:0], 1'b0};
            scan_out_r <= shift_r[DATA_W-1];
        end
    end

    assign scan_out = scan_out_r;

endmodule

// File: rtl/sram_packet_loader.sv
// Assembles a serial packet for the SRAM input controller, issues it, waits the read
// latency, then streams the selected read word back out on scan_out.
module sram_packet_loader
    import sram_packet_pkg::*;
#(
    parameter int PACKET_W = PACKET_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int READ_LAT = READ_LAT_DEF
) (
    input  logic              clk_in,
    input  logic              rst_n,
    sram_packet_loader_if.slave bus
);

    localparam int BIT_CNT_W = cnt_width(PACKET_W);
    localparam int UNL_CNT_W = cnt_width(DATA_W);

    localparam logic [BIT_CNT_W-1:0]  BIT_ONE   = BIT_CNT_W'(1);
    localparam logic [BIT_CNT_W-1:0]  BIT_PENULT = BIT_CNT_W'(PACKET_W - 1);
    localparam logic [UNL_CNT_W-1:0]  UNL_ONE   = UNL_CNT_W'(1);
    localparam logic [UNL_CNT_W-1:0]  UNL_LAST  = UNL_CNT_W'(DATA_W - 1);
    localparam logic [WAIT_CNT_W-1:0] WAIT_ONE  = WAIT_CNT_W'(1);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(READ_LAT);

    state_t                state_r;
    state_t                state_s;

    logic [PACKET_W-2:0]   shift_r;
    logic [BIT_CNT_W-1:0]  bit_cnt_r;
    logic                  cs_lat_r;
    logic [PACKET_W-1:0]   packet_r;
    logic                  chip_select_r;
    logic                  packet_valid_r;
    logic [WAIT_CNT_W-1:0] wait_cnt_r;
    logic [UNL_CNT_W-1:0]  unl_cnt_r;
    logic                  busy_r;
    logic                  frame_err_r;

    logic                  first_bit_s;
    logic                  shift_en_s;
    logic                  issue_s;
    logic                  abort_s;
    logic                  wait_load_s;
    logic                  wait_dec_s;
    logic                  capture_s;
    logic                  unl_shift_s;
    logic                  err_set_s;

    // State register.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and datapath strobes; the issue strobe fires on the last bit so the
    // packet register is already valid during the ISSUE cycle.
    always_comb begin
        state_s     = state_r;
        first_bit_s = 1'b0;
        shift_en_s  = 1'b0;
        issue_s     = 1'b0;
        abort_s     = 1'b0;
        wait_load_s = 1'b0;
        wait_dec_s  = 1'b0;
        capture_s   = 1'b0;
        unl_shift_s = 1'b0;
        err_set_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.scan_en) begin
                    first_bit_s = 1'b1;
                    state_s     = ST_SHIFT;
                end else begin
                    state_s     = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (!bus.scan_en) begin
                    abort_s    = 1'b1;
                    err_set_s  = 1'b1;
                    state_s    = ST_IDLE;
                end else if (bit_cnt_r == BIT_PENULT) begin
                    issue_s    = 1'b1;
                    state_s    = ST_ISSUE;
                end else begin
                    shift_en_s = 1'b1;
                end
            end
            ST_ISSUE: begin
                err_set_s   = bus.scan_en;
                wait_load_s = 1'b1;
                state_s     = ST_WAIT;
            end
            ST_WAIT: begin
                err_set_s = bus.scan_en;
                if (wait_cnt_r == WAIT_ONE) begin
                    capture_s  = 1'b1;
                    state_s    = ST_UNLOAD;
                end else begin
                    wait_dec_s = 1'b1;
                end
            end
            ST_UNLOAD: begin
                err_set_s   = bus.scan_en;
                unl_shift_s = 1'b1;
                if (unl_cnt_r == UNL_LAST) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_UNLOAD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Frame assembly: the final bit bypasses the shift register straight into packet.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            shift_r   <= '0;
            bit_cnt_r <= '0;
            cs_lat_r  <= 1'b0;
        end else if (first_bit_s) begin
            shift_r   <= {{(PACKET_W-2){1'b0}}, bus.scan_in};
            bit_cnt_r <= BIT_ONE;
            cs_lat_r  <= bus.cs_in;
        end else if (shift_en_s) begin
            shift_r   <= {shift_r[PACKET_W-3:0], bus.scan_in};
            bit_cnt_r <= bit_cnt_r + BIT_ONE;
        end else if (issue_s || abort_s) begin
            shift_r   <= '0;
            bit_cnt_r <= '0;
        end
    end

    // Issue registers; an aborted frame leaves packet and chip_select untouched.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            packet_r       <= '0;
            chip_select_r  <= 1'b0;
            packet_valid_r <= 1'b0;
        end else begin
            packet_valid_r <= issue_s;
            if (issue_s) begin
                packet_r      <= {shift_r, bus.scan_in};
                chip_select_r <= cs_lat_r;
            end
        end
    end

    // Read-latency and unload bit counters.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= '0;
            unl_cnt_r  <= '0;
        end else begin
            if (wait_load_s) begin
                wait_cnt_r <= WAIT_LOAD;
            end else if (wait_dec_s) begin
                wait_cnt_r <= wait_cnt_r - WAIT_ONE;
            end else if (capture_s) begin
                wait_cnt_r <= '0;
            end
            if (capture_s) begin
                unl_cnt_r <= '0;
            end else if (unl_shift_s) begin
                unl_cnt_r <= unl_cnt_r + UNL_ONE;
            end
        end
    end

    // Busy follows the state it will be in; a new error beats a same-cycle clear.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            busy_r      <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            busy_r <= (state_s != ST_IDLE);
            if (err_set_s) begin
                frame_err_r <= 1'b1;
            end else if (bus.err_clr) begin
                frame_err_r <= 1'b0;
            end
        end
    end

    readback_serializer #(
        .DATA_W (DATA_W)
    ) u_readback (
        .clk      (clk_in),
        .rst_n    (rst_n),
        .load     (capture_s),
        .shift    (unl_shift_s),
        .data     (bus.read_data),
        .scan_out (bus.scan_out)
    );

    assign bus.packet       = packet_r;
    assign bus.chip_select  = chip_select_r;
    assign bus.packet_valid = packet_valid_r;
    assign bus.busy         = busy_r;
    assign bus.frame_err    = frame_err_r;

endmodule

// File: tb/tb_sram_packet_loader.sv
// Directed bench for sram_packet_loader: a table of whole frames run back to back,
// plus hand-written abort, reset and error-flag sequences.
module tb_sram_packet_loader;

    localparam int PW = 55;
    localparam int DW = 32;
    localparam int RL = 2;

    typedef struct {
        logic [PW-1:0] pkt;
        logic          cs;
        logic [DW-1:0] rdata;
        logic [PW-1:0] exp_pkt;
        logic          exp_cs;
        logic [DW-1:0] exp_stream;
        int            inj_bit;
        logic          inj_clr;
        logic          exp_err;
    } vec_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    vec_t vecs [5];

    sram_packet_loader_if #(.PACKET_W(PW), .DATA_W(DW)) bus ();

    sram_packet_loader #(
        .PACKET_W (PW),
        .DATA_W   (DW),
        .READ_LAT (RL)
    ) dut (
        .clk_in (clk),
        .rst_n  (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_packet"}, 64'(bus.packet), 64'd0);
        check({tag, "_cs"},     64'(bus.chip_select), 64'd0);
        check({tag, "_pv"},     64'(bus.packet_valid), 64'd0);
        check({tag, "_so"},     64'(bus.scan_out), 64'd0);
        check({tag, "_busy"},   64'(bus.busy), 64'd0);
        check({tag, "_err"},    64'(bus.frame_err), 64'd0);
    endtask

    // Full frame: shift in, check issue, present read word at the sample edge, collect stream.
    task automatic run_frame(input vec_t v);
        logic [DW-1:0] got;
        for (int i = PW-1; i >= 0; i--) begin
            bus.scan_en = 1'b1;
            bus.scan_in = v.pkt[i];
            bus.cs_in   = (i == PW-1) ? v.cs : ~v.cs;
            bus.err_clr = (i == PW-1);
            if (i == 0) check("pv_before_issue", 64'(bus.packet_valid), 64'd0);
            step();
        end
        bus.scan_en   = 1'b0;
        bus.err_clr   = 1'b0;
        bus.read_data = ~v.rdata;
        check("issue_pv",     64'(bus.packet_valid), 64'd1);
        check("issue_packet", 64'(bus.packet), 64'(v.exp_pkt));
        check("issue_cs",     64'(bus.chip_select), 64'(v.exp_cs));
        check("issue_busy",   64'(bus.busy), 64'd1);
        check("issue_err",    64'(bus.frame_err), 64'd0);
        check("issue_so",     64'(bus.scan_out), 64'd0);
        for (int w = 1; w <= RL; w++) begin
            step();
            if (w == 1) check("pv_one_cycle", 64'(bus.packet_valid), 64'd0);
            bus.read_data = (w == RL) ? v.rdata : ~v.rdata;
        end
        step();
        bus.read_data = ~v.rdata;
        got = '0;
        for (int b = DW-1; b >= 0; b--) begin
            got[b] = bus.scan_out;
            if (b == v.inj_bit) begin
                bus.scan_en = 1'b1;
                bus.err_clr = v.inj_clr;
            end
            step();
            bus.scan_en = 1'b0;
            bus.err_clr = 1'b0;
        end
        check("stream",   64'(got), 64'(v.exp_stream));
        check("end_busy", 64'(bus.busy), 64'd0);
        check("end_so",   64'(bus.scan_out), 64'd0);
        check("end_err",  64'(bus.frame_err), 64'(v.exp_err));
    endtask

    task automatic shift_bits(input int n, input logic cs);
        for (int i = 0; i < n; i++) begin
            bus.scan_en = 1'b1;
            bus.scan_in = i[0];
            bus.cs_in   = cs;
            step();
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        vecs[0] = '{55'h55_AA55_AA55_AA55, 1'b1, 32'hDEAD_BEEF,
                    55'h55_AA55_AA55_AA55, 1'b1, 32'b1101_1110_1010_1101_1011_1110_1110_1111,
                    -1, 1'b0, 1'b0};
        vecs[1] = '{55'h7F_FFFF_FFFF_FFFF, 1'b0, 32'h8000_0001,
                    55'h7F_FFFF_FFFF_FFFF, 1'b0, 32'h8000_0001, -1, 1'b0, 1'b0};
        vecs[2] = '{55'h00_0000_0000_0001, 1'b1, 32'hFFFF_FFFF,
                    55'h00_0000_0000_0001, 1'b1, 32'hFFFF_FFFF, 20, 1'b0, 1'b1};
        vecs[3] = '{55'h40_0000_0000_0000, 1'b0, 32'h0000_0000,
                    55'h40_0000_0000_0000, 1'b0, 32'h0000_0000, 12, 1'b1, 1'b1};
        vecs[4] = '{55'h12_3456_789A_BCDE, 1'b1, 32'hA5A5_5A5A,
                    55'h12_3456_789A_BCDE, 1'b1, 32'hA5A5_5A5A, -1, 1'b0, 1'b0};

        rst_n         = 1'b0;
        bus.scan_en   = 1'b0;
        bus.scan_in   = 1'b0;
        bus.cs_in     = 1'b0;
        bus.err_clr   = 1'b0;
        bus.read_data = '0;
        step();
        step();
        check_all_zero("reset");
        rst_n = 1'b1;

        // Back-to-back frames: each starts in the first IDLE cycle after the previous unload.
        for (int k = 0; k < 5; k++) begin
            run_frame(vecs[k]);
        end

        // Frame dropped after 20 bits.
        shift_bits(20, 1'b0);
        bus.scan_en = 1'b0;
        step();
        check("abort_err",    64'(bus.frame_err), 64'd1);
        check("abort_busy",   64'(bus.busy), 64'd0);
        check("abort_pv",     64'(bus.packet_valid), 64'd0);
        step();
        step();
        check("abort_pv_late",  64'(bus.packet_valid), 64'd0);
        check("abort_packet",   64'(bus.packet), 64'(55'h12_3456_789A_BCDE));
        check("abort_cs",       64'(bus.chip_select), 64'd1);
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        check("err_clr", 64'(bus.frame_err), 64'd0);

        // Asynchronous reset at bit 30 with the error flag set.
        shift_bits(5, 1'b0);
        bus.scan_en = 1'b0;
        step();
        check("pre_reset_err", 64'(bus.frame_err), 64'd1);
        shift_bits(30, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        bus.scan_en = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("post_reset_pv",   64'(bus.packet_valid), 64'd0);
        check("post_reset_busy", 64'(bus.busy), 64'd0);
        run_frame(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
